// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the RV32I ALU and the instruction decoder.
//   ALU_XLEN  : default operand/result width
//   alu_op_e  : 4-bit ALU operation encodings (codes 4'hB..4'hF are unused)
package alu_pkg;

  localparam int ALU_XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// alu_comb: purely combinational RV32I ALU datapath and status flags.
// Ports:
//   a, b        : operands (XLEN bits)
//   alu_control : operation select (alu_op_e encoding)
//   result      : operation result
//   zero        : result == 0
//   negative    : result MSB
//   carry       : ADD carry-out / SUB not-borrow, 0 otherwise
//   overflow    : signed overflow for ADD/SUB, 0 otherwise
//   illegal_op  : alu_control is an unused code
module alu_comb
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow,
  output logic            illegal_op
);

  // One extra bit on each adder captures the carry-out. SUB is a + ~b + 1,
  // so its carry-out is 1 exactly when no borrow occurs (a >= b unsigned).
  logic [XLEN:0] add_full;
  logic [XLEN:0] sub_full;
  logic [4:0]    shamt;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};
  assign shamt    = b[4:0];

  always_comb begin
    result     = '0;
    carry      = 1'b0;
    overflow   = 1'b0;
    illegal_op = 1'b0;
    case (alu_control)
      ALU_ADD: begin
        result   = add_full[XLEN-1:0];
        carry    = add_full[XLEN];
        overflow = (a[XLEN-1] == b[XLEN-1]) && (add_full[XLEN-1] != a[XLEN-1]);
      end
      ALU_SUB: begin
        result   = sub_full[XLEN-1:0];
        carry    = sub_full[XLEN];
        overflow = (a[XLEN-1] != b[XLEN-1]) && (sub_full[XLEN-1] != a[XLEN-1]);
      end
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $signed(a) >>> shamt;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, a < b};
      ALU_PASSB: result = b;
      // Unused codes: result stays 0 (so zero = 1), only illegal_op is raised.
      default:   illegal_op = 1'b1;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[XLEN-1];

endmodule

// File: rtl/rv32_alu.sv
// rv32_alu: RV32I execute-stage ALU with a registered output stage.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   in_valid    : a, b, alu_control are valid this cycle
//   a, b        : operands
//   alu_control : operation select (alu_op_e)
//   out_valid   : in_valid delayed one cycle
//   alu_result, zero, negative, carry, overflow, illegal_op : registered result/flags
//
// Handshake: valid-only, no ready. A beat is accepted on every rising edge where
// in_valid = 1 (and rst = 0); its result appears after that edge with out_valid = 1
// for exactly one cycle. Result and flags then hold until the next accepted beat.
module rv32_alu
  import alu_pkg::*;
#(
  parameter int XLEN = ALU_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow,
  output logic            illegal_op
);

  logic [XLEN-1:0] c_result;
  logic            c_zero;
  logic            c_negative;
  logic            c_carry;
  logic            c_overflow;
  logic            c_illegal;

  alu_comb #(.XLEN(XLEN)) u_comb (
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .result      (c_result),
    .zero        (c_zero),
    .negative    (c_negative),
    .carry       (c_carry),
    .overflow    (c_overflow),
    .illegal_op  (c_illegal)
  );

  // Reset wins over in_valid, so a beat presented during reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      alu_result <= '0;
      zero       <= 1'b1;
      negative   <= 1'b0;
      carry      <= 1'b0;
      overflow   <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        alu_result <= c_result;
        zero       <= c_zero;
        negative   <= c_negative;
        carry      <= c_carry;
        overflow   <= c_overflow;
        illegal_op <= c_illegal;
      end
    end
  end

endmodule

// File: tb/tb_rv32_alu.sv
// tb_rv32_alu: directed-vector bench for rv32_alu with hand-computed expectations.
// Observed/expected words are packed as {out_valid, result[31:0], zero, negative,
// carry, overflow, illegal_op}.
module tb_rv32_alu;

  localparam int W = 38;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  alu_control;
  logic        out_valid;
  logic [31:0] alu_result;
  logic        zero;
  logic        negative;
  logic        carry;
  logic        overflow;
  logic        illegal_op;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  rv32_alu dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .a           (a),
    .b           (b),
    .alu_control (alu_control),
    .out_valid   (out_valid),
    .alu_result  (alu_result),
    .zero        (zero),
    .negative    (negative),
    .carry       (carry),
    .overflow    (overflow),
    .illegal_op  (illegal_op)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  function automatic logic [W-1:0] observed();
    return {out_valid, alu_result, zero, negative, carry, overflow, illegal_op};
  endfunction

  // flags = {zero, negative, carry, overflow, illegal_op}
  function automatic logic [W-1:0] pack(input logic v, input logic [31:0] r,
                                        input logic [4:0] flags);
    return {v, r, flags};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got v=%b res=%h zncvi=%b, expected v=%b res=%h zncvi=%b",
               tag, got[37], got[36:5], got[4:0], exp[37], exp[36:5], exp[4:0]);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] av,
                       input logic [31:0] bv);
    @(negedge clk);
    in_valid    = v;
    alu_control = op;
    a           = av;
    b           = bv;
  endtask

  // Issue one beat, then check the registered output just after the edge.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_res,
                        input logic [4:0] exp_flags);
    drive(1'b1, op, av, bv);
    exp_q.push_back(pack(1'b1, exp_res, exp_flags));
    @(posedge clk);
    #1;
    check(tag, observed(), exp_q.pop_front());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] last;
    rst         = 1'b1;
    in_valid    = 1'b1;
    a           = 32'hDEAD_BEEF;
    b           = 32'h1234_5678;
    alu_control = 4'b0000;

    // Reset held two cycles with a live beat on the inputs.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset", observed(), pack(1'b0, 32'h0, 5'b10000));
      drive(1'b1, 4'(i + 1), 32'hFFFF_FFFF, 32'h7FFF_FFFF);
    end
    @(negedge clk);
    rst = 1'b0;

    //                op       a              b              result         zncvi
    run_op("add",     4'b0000, 32'd5,         32'd10,        32'd15,        5'b00000);
    run_op("sub",     4'b0001, 32'd12,        32'd7,         32'd5,         5'b00100);
    run_op("add_ovf", 4'b0000, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 5'b01010);
    run_op("add_cy",  4'b0000, 32'hFFFF_FFFF, 32'd1,         32'h0,         5'b10100);
    run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 5'b00110);
    run_op("sub_brw", 4'b0001, 32'd3,         32'd5,         32'hFFFF_FFFE, 5'b01000);
    run_op("sub_eq",  4'b0001, 32'd7,         32'd7,         32'h0,         5'b10100);
    run_op("sra",     4'b0111, 32'h8000_0000, 32'd4,         32'hF800_0000, 5'b01000);
    run_op("srl",     4'b0110, 32'h8000_0000, 32'd4,         32'h0800_0000, 5'b00000);
    run_op("sll",     4'b0101, 32'd1,         32'h21,        32'd2,         5'b00000);
    run_op("sra_hi",  4'b0111, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'b01000);
    run_op("slt",     4'b1000, 32'hFFFF_FFFF, 32'd1,         32'd1,         5'b00000);
    run_op("sltu",    4'b1001, 32'hFFFF_FFFF, 32'd1,         32'd0,         5'b10000);
    run_op("sltu_lt", 4'b1001, 32'd1,         32'hFFFF_FFFF, 32'd1,         5'b00000);
    run_op("and",     4'b0010, 32'hF0F0,      32'hFF00,      32'hF000,      5'b00000);
    run_op("or",      4'b0011, 32'hF0F0,      32'hFF00,      32'hFFF0,      5'b00000);
    run_op("xor",     4'b0100, 32'hF0F0,      32'hFF00,      32'h0FF0,      5'b00000);
    run_op("passb",   4'b1010, 32'hAAAA_AAAA, 32'h1234_5000, 32'h1234_5000, 5'b00000);
    run_op("ill_f",   4'b1111, 32'hFFFF_FFFF, 32'd1,         32'h0,         5'b10001);
    run_op("ill_b",   4'b1011, 32'h8000_0000, 32'h8000_0000, 32'h0,         5'b10001);

    // Back-to-back beats: each result lands on the cycle after its issue edge.
    drive(1'b1, 4'b0000, 32'd1, 32'd2);
    exp_q.push_back(pack(1'b1, 32'd3, 5'b00000));
    @(posedge clk);
    #1;
    check("pipe_add", observed(), exp_q.pop_front());
    drive(1'b1, 4'b0001, 32'd10, 32'd3);
    exp_q.push_back(pack(1'b1, 32'd7, 5'b00100));
    @(posedge clk);
    #1;
    check("pipe_sub", observed(), exp_q.pop_front());
    drive(1'b1, 4'b0100, 32'hFF, 32'h0F);
    last = pack(1'b1, 32'hF0, 5'b00000);
    exp_q.push_back(last);
    @(posedge clk);
    #1;
    check("pipe_xor", observed(), exp_q.pop_front());

    // Idle cycles: result and flags hold, out_valid drops.
    drive(1'b0, 4'b0000, 32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("hold", observed(), {1'b0, last[W-2:0]});
    end

    // Reset mid-stream with a beat presented: beat dropped, reset values appear.
    drive(1'b1, 4'b0000, 32'd100, 32'd200);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid", observed(), pack(1'b0, 32'h0, 5'b10000));

    // Recovery after reset.
    @(negedge clk);
    rst = 1'b0;
    run_op("post_rst", 4'b0000, 32'd100, 32'd200, 32'd300, 5'b00000);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL exp_q: %0d entries left, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_alu.md
Name: rv32_alu

Overview:
- 32-bit integer ALU for the RV32I execute stage.
- Takes two operands and a 4-bit operation select, and produces a 32-bit result plus status flags.
- Outputs are registered: one-cycle latency, valid-qualified.
- Sits between the register-read/operand-mux stage and the memory/writeback stage.

Parameters:
- XLEN, 32, operand and result width. Only 32 is required to work.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands and alu_control are valid this cycle.
- a  input  XLEN  operand A (rs1 or PC).
- b  input  XLEN  operand B (rs2 or immediate).
- alu_control  input  4  operation select, encoding below.
- out_valid  output  1  alu_result and flags are valid.
- alu_result  output  XLEN  registered result.
- zero  output  1  registered: alu_result == 0.
- negative  output  1  registered: alu_result[XLEN-1].
- carry  output  1  registered: carry-out of ADD; NOT borrow for SUB; 0 for other ops.
- overflow  output  1  registered: signed overflow for ADD/SUB; 0 for other ops.
- illegal_op  output  1  registered: alu_control was an unused code.

Behaviour:
- Encoding of alu_control:
  - 0000 ADD: a+b
  - 0001 SUB: a-b
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SLL: a << b[4:0]
  - 0110 SRL: logical right shift by b[4:0]
  - 0111 SRA: arithmetic right shift by b[4:0]
  - 1000 SLT: signed a<b gives 1, else 0
  - 1001 SLTU: unsigned a<b gives 1, else 0
  - 1010 PASSB: result = b (LUI)
  - 1011–1111 unused.
- Arithmetic is modulo 2^32; wrap-around is silent except through the carry/overflow flags.
- Shift amount uses only b[4:0]; b[31:5] is ignored.
- SUB is computed as a + ~b + 1.
  - carry = 1 means no borrow (a >= b unsigned).
  - overflow = (a[31] != b[31]) && (result[31] != a[31]).
- ADD overflow = (a[31] == b[31]) && (result[31] != a[31]).
- Unused codes: alu_result = 0, zero = 1, illegal_op = 1, all other flags 0.
- Latency: inputs sampled at rising edge N when in_valid = 1; results appear after edge N and are held until the next valid input.
  - out_valid is in_valid delayed by one cycle.
- When in_valid = 0: alu_result and all flags hold their previous value; out_valid = 0 next cycle.
- Back-to-back: a new operation may be issued every cycle with no bubbles; no backpressure.
- Reset (synchronous, rst = 1 at a rising edge):
  - alu_result = 0, out_valid = 0, zero = 1, negative = 0, carry = 0, overflow = 0, illegal_op = 0.
  - rst has priority over in_valid on the same edge; the input is dropped.
  - Reset mid-stream discards any in-flight result.
- No X propagation: all outputs are defined after reset regardless of input values.

Decomposition:
- Shared package alu_pkg:
  - alu_op_e enum with the 4-bit encodings above (ALU_ADD … ALU_PASSB).
  - XLEN default constant.
  - Shared with the decoder.
- One natural sub-module, alu_comb: purely combinational result and flag computation.
- rv32_alu wraps alu_comb with the output register stage, valid pipeline and reset.

Test Plan:
- Reset: assert rst 2 cycles with in_valid = 1 and arbitrary operands → alu_result = 0, out_valid = 0, zero = 1, all other flags 0.
- ADD/SUB basic: a = 5, b = 10, ADD → 15 one cycle later, out_valid = 1. Then a = 12, b = 7, SUB → 5, carry = 1, overflow = 0.
- Arithmetic edge cases:
  - 0x7FFFFFFF + 1 → 0x80000000, overflow = 1, negative = 1.
  - 0xFFFFFFFF + 1 → 0, carry = 1, zero = 1.
  - 0x80000000 − 1 → 0x7FFFFFFF, overflow = 1.
  - 3 − 5 → 0xFFFFFFFE, carry = 0.
- Shifts and compares:
  - 0x80000000 SRA 4 → 0xF8000000.
  - SRL 4 → 0x08000000.
  - 1 SLL 0x21 → 2 (b[4:0] = 1).
  - SLT(−1, 1) → 1; SLTU(0xFFFFFFFF, 1) → 0.
- Logic/pass/illegal:
  - 0xF0F0 AND 0xFF00 → 0xF000; OR → 0xFFF0; XOR → 0x0FF0.
  - PASSB b = 0x12345000 → 0x12345000.
  - code 1111 → 0, illegal_op = 1.
- Pipelining/hold: issue ADD, SUB, XOR on consecutive cycles → results on consecutive cycles. Then drop in_valid → result held, out_valid = 0. Assert rst mid-stream → outputs return to reset values on the next edge.
